// File: rtl/writeback_arbiter.sv
// Write-back arbiter: shares the single register-file write port between
// the ALU and the load/store unit. LSU wins contention by default; after
// STARVE_LIMIT consecutive lost contentions the ALU is given priority until
// it is served once. The winning write is registered and driven for the
// whole following cycle so the register file can commit on the negedge.
//
// Handshake: a transfer happens in any cycle where valid && ready. A
// requester holds valid/rd/data stable until it sees ready. ready is a
// combinational function of the two valids, reset and the arbiter state
// only; rd and data never feed it.
module writeback_arbiter #(
   parameter int DATA_WIDTH   = 32,
   parameter int ADDR_WIDTH   = 5,
   parameter int STARVE_LIMIT = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  alu_valid,
   input  logic [ADDR_WIDTH-1:0] alu_rd,
   input  logic [DATA_WIDTH-1:0] alu_data,
   output logic                  alu_ready,
   input  logic                  lsu_valid,
   input  logic [ADDR_WIDTH-1:0] lsu_rd,
   input  logic [DATA_WIDTH-1:0] lsu_data,
   output logic                  lsu_ready,
   output logic [ADDR_WIDTH-1:0] rf_address_3,
   output logic [DATA_WIDTH-1:0] rf_write_data,
   output logic                  rf_write_enable,
   output logic                  prio_alu,
   output logic [7:0]            conflict_count
);

   typedef enum logic {
      LSU_FIRST = 1'b0,
      ALU_FIRST = 1'b1
   } state_t;

   // Counter hits the limit on the contention that takes it from LIMIT-1.
   localparam logic [3:0] LAST_LOSS = 4'(STARVE_LIMIT - 1);

   state_t                state_q, state_d;
   logic [3:0]            starve_q, starve_d;
   logic [7:0]            conflict_q, conflict_d;
   logic                  rf_we_q, rf_we_d;
   logic [ADDR_WIDTH-1:0] rf_addr_q, rf_addr_d;
   logic [DATA_WIDTH-1:0] rf_data_q, rf_data_d;
   logic                  both_valid;

   assign both_valid = alu_valid & lsu_valid;

   // Grant: single requester always wins; contention resolved by state.
   always_comb begin
      alu_ready = 1'b0;
      lsu_ready = 1'b0;
      if (!reset) begin
         if (both_valid) begin
            if (state_q == ALU_FIRST) alu_ready = 1'b1;
            else                      lsu_ready = 1'b1;
         end else begin
            alu_ready = alu_valid;
            lsu_ready = lsu_valid;
         end
      end
   end

   // Priority FSM and starvation counter next-state.
   always_comb begin
      state_d  = state_q;
      starve_d = starve_q;
      case (state_q)
         LSU_FIRST: begin
            if (alu_ready) begin
               starve_d = 4'd0;
            end else if (lsu_ready && alu_valid) begin
               if (starve_q == LAST_LOSS) begin
                  state_d  = ALU_FIRST;
                  starve_d = 4'd0;
               end else begin
                  starve_d = starve_q + 4'd1;
               end
            end
         end
         ALU_FIRST: begin
            if (alu_ready) begin
               state_d  = LSU_FIRST;
               starve_d = 4'd0;
            end
         end
         default: begin
            state_d  = LSU_FIRST;
            starve_d = 4'd0;
         end
      endcase
   end

   // Saturating contention counter.
   always_comb begin
      conflict_d = conflict_q;
      if (both_valid && (conflict_q != 8'hFF)) conflict_d = conflict_q + 8'd1;
   end

   // Output write register: winner's rd/data; writes to x0 are suppressed.
   always_comb begin
      rf_we_d   = 1'b0;
      rf_addr_d = rf_addr_q;
      rf_data_d = rf_data_q;
      if (lsu_ready) begin
         rf_we_d   = (lsu_rd != '0);
         rf_addr_d = lsu_rd;
         rf_data_d = lsu_data;
      end else if (alu_ready) begin
         rf_we_d   = (alu_rd != '0);
         rf_addr_d = alu_rd;
         rf_data_d = alu_data;
      end
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= LSU_FIRST;
         starve_q   <= 4'd0;
         conflict_q <= 8'd0;
         rf_we_q    <= 1'b0;
         rf_addr_q  <= '0;
         rf_data_q  <= '0;
      end else begin
         state_q    <= state_d;
         starve_q   <= starve_d;
         conflict_q <= conflict_d;
         rf_we_q    <= rf_we_d;
         rf_addr_q  <= rf_addr_d;
         rf_data_q  <= rf_data_d;
      end
   end

   assign rf_write_enable = rf_we_q;
   assign rf_address_3    = rf_addr_q;
   assign rf_write_data   = rf_data_q;
   assign prio_alu        = (state_q == ALU_FIRST);
   assign conflict_count  = conflict_q;

endmodule

// File: tb/tb_writeback_arbiter.sv
// Bench for writeback_arbiter: directed scenarios plus a randomized run
// compared against a behavioural model of the arbitration rules.
module tb_writeback_arbiter;

   localparam int DW = 32;
   localparam int AW = 5;
   localparam int SL = 4;

   logic          clk = 1'b0;
   logic          reset;
   logic          alu_valid, lsu_valid;
   logic [AW-1:0] alu_rd, lsu_rd;
   logic [DW-1:0] alu_data, lsu_data;
   logic          alu_ready, lsu_ready;
   logic [AW-1:0] rf_address_3;
   logic [DW-1:0] rf_write_data;
   logic          rf_write_enable;
   logic          prio_alu;
   logic [7:0]    conflict_count;

   int tests_run    = 0;
   int tests_failed = 0;

   // Behavioural model state
   bit            m_prio;
   int            m_starve;
   int            m_conflict;
   bit            m_we;
   logic [AW-1:0] m_addr;
   logic [DW-1:0] m_data;

   // Register file image built from what the DUT drives
   logic [DW-1:0] rf_mem [32];

   writeback_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .STARVE_LIMIT(SL)) dut (
      .clk(clk), .reset(reset),
      .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
      .lsu_valid(lsu_valid), .lsu_rd(lsu_rd), .lsu_data(lsu_data), .lsu_ready(lsu_ready),
      .rf_address_3(rf_address_3), .rf_write_data(rf_write_data),
      .rf_write_enable(rf_write_enable), .prio_alu(prio_alu),
      .conflict_count(conflict_count)
   );

   // Clock / reset
   always #5 clk = ~clk;

   // Expected grant {alu, lsu} from the arbitration rules
   function automatic logic [1:0] model_grant();
      if (reset) return 2'b00;
      if (alu_valid && lsu_valid) return m_prio ? 2'b10 : 2'b01;
      return {alu_valid, lsu_valid};
   endfunction

   always @(posedge clk) begin : model
      logic [1:0] g;
      g = model_grant();
      if (reset) begin
         m_prio = 0; m_starve = 0; m_conflict = 0;
         m_we = 0; m_addr = '0; m_data = '0;
      end else begin
         if (alu_valid && lsu_valid && m_conflict < 255) m_conflict++;
         if (g[1]) begin
            m_starve = 0;
            m_prio   = 0;
         end else if (g[0] && alu_valid) begin
            m_starve++;
            if (m_starve == SL) begin
               m_prio   = 1;
               m_starve = 0;
            end
         end
         if (g[1]) begin
            m_we = (alu_rd != 0); m_addr = alu_rd; m_data = alu_data;
         end else if (g[0]) begin
            m_we = (lsu_rd != 0); m_addr = lsu_rd; m_data = lsu_data;
         end else begin
            m_we = 0;
         end
      end
   end

   always @(negedge clk) if (rf_write_enable) rf_mem[rf_address_3] <= rf_write_data;

   // Driver tasks
   task automatic drive(input logic av, input logic [AW-1:0] ar, input logic [DW-1:0] ad,
                        input logic lv, input logic [AW-1:0] lr, input logic [DW-1:0] ld);
      alu_valid = av; alu_rd = ar; alu_data = ad;
      lsu_valid = lv; lsu_rd = lr; lsu_data = ld;
   endtask

   task automatic next_cycle();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic apply_reset();
      drive(0, 0, 0, 0, 0, 0);
      reset = 1'b1;
      next_cycle();
      next_cycle();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      drive(1, 4, 32'h1, 1, 6, 32'h2);
      next_cycle();
      #1;
      tests_run++;
      if ({alu_ready, lsu_ready} !== 2'b00) begin
         tests_failed++;
         $display("FAIL reset_ready: got %b expected 00", {alu_ready, lsu_ready});
      end
      next_cycle();
      reset = 1'b0;
      drive(0, 0, 0, 0, 0, 0);
      tests_run++;
      if (rf_write_enable !== 1'b0 || rf_address_3 !== '0 || rf_write_data !== '0 ||
          prio_alu !== 1'b0 || conflict_count !== 8'd0) begin
         tests_failed++;
         $display("FAIL reset_state: got we=%b a=%0d d=%h p=%b c=%0d expected all 0",
                  rf_write_enable, rf_address_3, rf_write_data, prio_alu, conflict_count);
      end
   endtask

   task automatic test_alu_only();
      apply_reset();
      drive(1, 5, 32'hDEADBEEF, 0, 0, 0);
      #1;
      tests_run++;
      if ({alu_ready, lsu_ready} !== 2'b10) begin
         tests_failed++;
         $display("FAIL alu_only_ready: got %b expected 10", {alu_ready, lsu_ready});
      end
      next_cycle();
      drive(0, 0, 0, 0, 0, 0);
      tests_run++;
      if (rf_write_enable !== 1'b1 || rf_address_3 !== 5'd5 || rf_write_data !== 32'hDEADBEEF) begin
         tests_failed++;
         $display("FAIL alu_only_write: got we=%b a=%0d d=%h expected 1/5/deadbeef",
                  rf_write_enable, rf_address_3, rf_write_data);
      end
      next_cycle();
      tests_run++;
      if (rf_write_enable !== 1'b0) begin
         tests_failed++;
         $display("FAIL alu_only_idle: got we=%b expected 0", rf_write_enable);
      end
   endtask

   task automatic test_contention();
      logic [DW-1:0] ld;
      logic          exp_alu;
      apply_reset();
      ld = 32'h22;
      drive(1, 1, 32'h11, 1, 2, ld);
      for (int i = 0; i < 6; i++) begin
         #1;
         exp_alu = (i == 4);
         tests_run++;
         if ({alu_ready, lsu_ready} !== {exp_alu, !exp_alu} || prio_alu !== exp_alu) begin
            tests_failed++;
            $display("FAIL contention_grant%0d: got ready=%b prio=%b expected ready=%b prio=%b",
                     i, {alu_ready, lsu_ready}, prio_alu, {exp_alu, !exp_alu}, exp_alu);
         end
         next_cycle();
         tests_run++;
         if (rf_write_enable !== 1'b1 || rf_address_3 !== (exp_alu ? 5'd1 : 5'd2) ||
             rf_write_data !== (exp_alu ? 32'h11 : ld)) begin
            tests_failed++;
            $display("FAIL contention_write%0d: got a=%0d d=%h expected a=%0d d=%h", i,
                     rf_address_3, rf_write_data, exp_alu ? 1 : 2, exp_alu ? 32'h11 : ld);
         end
         if (i == 4) begin
            tests_run++;
            if (conflict_count !== 8'd5) begin
               tests_failed++;
               $display("FAIL contention_count: got %0d expected 5", conflict_count);
            end
         end
         if (!exp_alu) begin
            ld = ld + 32'h11;
            lsu_data = ld;
         end
      end
      drive(0, 0, 0, 0, 0, 0);
   endtask

   task automatic test_x0();
      apply_reset();
      drive(0, 0, 0, 1, 0, 32'hFFFFFFFF);
      #1;
      tests_run++;
      if (lsu_ready !== 1'b1) begin
         tests_failed++;
         $display("FAIL x0_ready: got %b expected 1", lsu_ready);
      end
      next_cycle();
      drive(0, 0, 0, 0, 0, 0);
      tests_run++;
      if (rf_write_enable !== 1'b0) begin
         tests_failed++;
         $display("FAIL x0_write: got we=%b expected 0", rf_write_enable);
      end
   endtask

   task automatic test_same_rd();
      apply_reset();
      drive(1, 7, 32'hA, 1, 7, 32'hB);
      #1;
      tests_run++;
      if ({alu_ready, lsu_ready} !== 2'b01) begin
         tests_failed++;
         $display("FAIL same_rd_first: got %b expected 01", {alu_ready, lsu_ready});
      end
      next_cycle();
      lsu_valid = 1'b0;
      tests_run++;
      if (rf_write_enable !== 1'b1 || rf_address_3 !== 5'd7 || rf_write_data !== 32'hB) begin
         tests_failed++;
         $display("FAIL same_rd_w1: got we=%b a=%0d d=%h expected 1/7/b",
                  rf_write_enable, rf_address_3, rf_write_data);
      end
      next_cycle();
      alu_valid = 1'b0;
      tests_run++;
      if (rf_write_enable !== 1'b1 || rf_address_3 !== 5'd7 || rf_write_data !== 32'hA) begin
         tests_failed++;
         $display("FAIL same_rd_w2: got we=%b a=%0d d=%h expected 1/7/a",
                  rf_write_enable, rf_address_3, rf_write_data);
      end
      next_cycle();
      #1;
      tests_run++;
      if (rf_mem[7] !== 32'hA) begin
         tests_failed++;
         $display("FAIL same_rd_final: got %h expected a", rf_mem[7]);
      end
   endtask

   task automatic test_reset_mid();
      apply_reset();
      drive(1, 9, 32'h99, 1, 3, 32'h333);
      next_cycle();
      reset = 1'b1;
      #1;
      tests_run++;
      if (rf_write_enable !== 1'b1 || rf_address_3 !== 5'd3 || {alu_ready, lsu_ready} !== 2'b00) begin
         tests_failed++;
         $display("FAIL reset_mid_pre: got we=%b a=%0d ready=%b expected 1/3/00",
                  rf_write_enable, rf_address_3, {alu_ready, lsu_ready});
      end
      next_cycle();
      tests_run++;
      if (rf_write_enable !== 1'b0 || conflict_count !== 8'd0 || prio_alu !== 1'b0 ||
          {alu_ready, lsu_ready} !== 2'b00) begin
         tests_failed++;
         $display("FAIL reset_mid_post: got we=%b c=%0d p=%b ready=%b expected 0/0/0/00",
                  rf_write_enable, conflict_count, prio_alu, {alu_ready, lsu_ready});
      end
      reset = 1'b0;
      drive(0, 0, 0, 0, 0, 0);
      next_cycle();
   endtask

   task automatic test_saturation();
      apply_reset();
      drive(1, 1, 32'h1, 1, 2, 32'h2);
      for (int i = 0; i < 300; i++) begin
         next_cycle();
         if (i == 253) begin
            tests_run++;
            if (conflict_count !== 8'd254) begin
               tests_failed++;
               $display("FAIL sat_254: got %0d expected 254", conflict_count);
            end
         end
      end
      tests_run++;
      if (conflict_count !== 8'd255) begin
         tests_failed++;
         $display("FAIL sat_255: got %0d expected 255", conflict_count);
      end
      drive(0, 0, 0, 0, 0, 0);
   endtask

   task automatic test_random();
      logic [1:0] g;
      logic [1:0] last_g;
      int         bad;
      apply_reset();
      last_g = 2'b00;
      bad    = 0;
      for (int i = 0; i < 600; i++) begin
         if (!alu_valid || last_g[1]) begin
            alu_valid = ($urandom_range(0, 3) != 0);
            alu_rd    = AW'($urandom_range(0, 31));
            alu_data  = $urandom;
         end
         if (!lsu_valid || last_g[0]) begin
            lsu_valid = ($urandom_range(0, 3) != 0);
            lsu_rd    = AW'($urandom_range(0, 31));
            lsu_data  = $urandom;
         end
         reset = ($urandom_range(0, 59) == 0);
         #1;
         g = model_grant();
         tests_run++;
         if ({alu_ready, lsu_ready} !== g) begin
            tests_failed++;
            bad++;
            if (bad < 10) $display("FAIL rand_ready%0d: got %b expected %b", i, {alu_ready, lsu_ready}, g);
         end
         last_g = g;
         next_cycle();
         tests_run++;
         if (rf_write_enable !== m_we || (m_we && (rf_address_3 !== m_addr || rf_write_data !== m_data)) ||
             prio_alu !== m_prio || conflict_count !== 8'(m_conflict)) begin
            tests_failed++;
            bad++;
            if (bad < 10)
               $display("FAIL rand_out%0d: got we=%b a=%0d d=%h p=%b c=%0d expected we=%b a=%0d d=%h p=%b c=%0d",
                        i, rf_write_enable, rf_address_3, rf_write_data, prio_alu, conflict_count,
                        m_we, m_addr, m_data, m_prio, m_conflict);
         end
      end
      reset = 1'b0;
      drive(0, 0, 0, 0, 0, 0);
   endtask

   initial begin
      reset = 1'b1;
      drive(0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 32; i++) rf_mem[i] = '0;
      @(negedge clk);
      test_reset();
      test_alu_only();
      test_contention();
      test_x0();
      test_same_rd();
      test_reset_mid();
      test_saturation();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/writeback_arbiter.md
Name: writeback_arbiter

Overview:
Shares the register file's single write port (address_3 / write_data / write_enable) between two write-back requesters: the ALU and the load/store unit (LSU).
- Each requester presents a destination register and data with a valid/ready handshake.
- The arbiter grants one per cycle and registers the winning write onto the register-file write port.
- The register file commits on the following negedge.
- Priority is LSU-first, with a starvation guard so the ALU cannot be locked out.

Parameters:
DATA_WIDTH, 32, width of write-back data
ADDR_WIDTH, 5, register index width (32 registers)
STARVE_LIMIT, 4, consecutive lost contentions after which ALU gets priority (legal range 1..15)

Ports:
clk  input  1  clock; all state updates on posedge
reset  input  1  synchronous, active-high reset
alu_valid  input  1  ALU write-back request
alu_rd  input  ADDR_WIDTH  ALU destination register
alu_data  input  DATA_WIDTH  ALU result
alu_ready  output  1  ALU request accepted this cycle (combinational)
lsu_valid  input  1  LSU write-back request
lsu_rd  input  ADDR_WIDTH  LSU destination register
lsu_data  input  DATA_WIDTH  load data
lsu_ready  output  1  LSU request accepted this cycle (combinational)
rf_address_3  output  ADDR_WIDTH  to register file write address
rf_write_data  output  DATA_WIDTH  to register file write data
rf_write_enable  output  1  to register file write enable
prio_alu  output  1  status: arbiter currently in ALU_FIRST state
conflict_count  output  8  saturating count of cycles with both requesters valid

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high; ports named clk and reset.
- Reset: state is LSU_FIRST; starvation counter = 0; conflict_count = 0; rf_write_enable = 0; rf_address_3 = 0; rf_write_data = 0; prio_alu = 0.
- Reset overrides the handshake: while reset is high, alu_ready = lsu_ready = 0.
- Handshake: a transfer occurs when valid && ready in the same cycle.
  - A requester holds valid, rd and data stable until ready.
  - ready depends only on both valids and the current state (no comb path from data/rd).
- Grant rules (not in reset):
  - Only one valid: that requester gets ready = 1.
  - Both valid, state LSU_FIRST: lsu_ready = 1, alu_ready = 0.
  - Both valid, state ALU_FIRST: alu_ready = 1, lsu_ready = 0.
  - Neither valid: both ready = 0.
- FSM:
  - LSU_FIRST:
    - On each cycle with both valid and the LSU granted, starve counter +1.
    - On any ALU grant, counter clears to 0.
    - When the counter reaches STARVE_LIMIT at a posedge, go to ALU_FIRST and clear the counter.
  - ALU_FIRST:
    - Stay until the ALU is granted, then return to LSU_FIRST.
    - An LSU-only grant while the ALU is idle does not change state.
  - prio_alu = 1 exactly while in ALU_FIRST (registered).
- Write port timing: a transfer accepted in cycle N is driven on rf_address_3 / rf_write_data / rf_write_enable for the whole of cycle N+1.
  - The outputs are registered and stable across that cycle's negedge, so the register file commits mid-cycle N+1.
  - With no transfer in cycle N, rf_write_enable = 0 in N+1; rf_address_3 / rf_write_data hold their previous values.
- Register 0: a transfer with rd = 0 completes the handshake normally (ready = 1, counters update as any grant), but rf_write_enable stays 0 for that slot.
- Throughput: one write per cycle sustained; no internal buffering beyond the output register.
- Same rd from both requesters simultaneously: no merging; writes are issued in grant order, so the later-granted value is the final register content.
- conflict_count: +1 on each non-reset cycle with alu_valid && lsu_valid; saturates at 255.
- Reset mid-operation: an in-flight output-register write is dropped (rf_write_enable = 0 in the cycle after reset is sampled); pending requests are not accepted until reset deasserts.

Test Plan:
1. ALU only: alu_valid = 1, rd = 5, data = 0xDEADBEEF for one cycle -> alu_ready = 1 that cycle; next cycle rf_write_enable = 1, rf_address_3 = 5, rf_write_data = 0xDEADBEEF; following cycle rf_write_enable = 0.
2. Contention: both valid continuously (ALU rd = 1 / 0x11, LSU rd = 2 with 0x22, 0x33, ...) with STARVE_LIMIT = 4 -> LSU granted 4 cycles, prio_alu = 1, ALU granted 5th cycle, then LSU again; conflict_count = 5 after 5 cycles.
3. x0 write: lsu_valid, rd = 0, data = 0xFFFFFFFF -> lsu_ready = 1; next cycle rf_write_enable = 0.
4. Same rd: ALU and LSU both target rd = 7 (ALU 0xA, LSU 0xB) in LSU_FIRST -> rf writes 0xB then 0xA in consecutive cycles; register 7 ends at 0xA.
5. Reset mid-stream: assert reset in the cycle after an accepted write (rd = 3) -> rf_write_enable = 0 in the next cycle, readies 0 during reset, conflict_count = 0, prio_alu = 0.
6. Saturation: hold both valid for 300 cycles -> conflict_count stops at 255.
